dsp_sum_normalizer: RTL and testbench

Output end of the 24-bit adder tree in the spatial filter datapath. Accepts two 25-bit signed sum lanes from the final `dsp_adder24` stage and applies kernel-weight normalisation: arithmetic right shift, optional rounding, saturation to signed 24 bits. It is a 2-stage valid/ready pipeline that feeds the pixel output formatter. It also keeps a saturation-event counter for filter coefficient tuning.

---
 rtl/dsp_pkg.sv | 14 +
 rtl/dsp_norm_lane.sv | 51 +++++
 rtl/dsp_sum_normalizer.sv | 104 ++++++++++
 tb/tb_dsp_sum_normalizer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared datapath package for the spatial filter adder tree and its output normaliser.
// Holds the default lane widths, the signed 24-bit saturation limits and the lane sample types.
package dsp_pkg;

  localparam int DEF_IN_W  = 25;
  localparam int DEF_OUT_W = 24;

  typedef logic signed [DEF_IN_W-1:0]  in_sample_t;
  typedef logic signed [DEF_OUT_W-1:0] out_sample_t;

  localparam out_sample_t OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam out_sample_t OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/dsp_norm_lane.sv
// Combinational per-lane normalisation: round+shift ahead of stage 1, clamp+flag ahead of stage 2.
// The rounding adder exists only when DSP_NORM_ROUND_EN is defined; otherwise the shift truncates (floor).
module dsp_norm_lane
  import dsp_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = 3
) (
  input  logic signed [IN_W-1:0]  sum,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [IN_W:0]    shifted,
  input  logic signed [IN_W:0]    held,
  output logic signed [OUT_W-1:0] clamped,
  output logic                    sat
);

  // Clamp limits widened to the IN_W+1 intermediate so comparisons stay signed.
  localparam logic signed [IN_W:0] HI = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] LO = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x,
                                                       input logic [SHIFT_W-1:0] sh);
    logic signed [IN_W:0] t;
    t = {x[IN_W-1], x};
`ifdef DSP_NORM_ROUND_EN
    if (sh != '0) begin
      t = t + ({{IN_W{1'b0}}, 1'b1} << (sh - 1'b1));
    end
`endif
    return t >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
    if (v > HI) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < LO) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end
    return v[OUT_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [IN_W:0] v);
    return (v > HI) || (v < LO);
  endfunction

  assign shifted = round_shift(sum, shift);
  assign clamped = saturate(held);
  assign sat     = out_of_range(held);

endmodule

// File: rtl/dsp_sum_normalizer.sv
// Two-stage valid/ready normaliser at the end of the adder tree, with a saturation-event counter.
// Build option: define DSP_NORM_ROUND_EN for round-half-up; default build truncates.
module dsp_sum_normalizer
  import dsp_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic signed [IN_W-1:0]  IN1,
  input  logic signed [IN_W-1:0]  IN2,
  input  logic [SHIFT_W-1:0]      SHIFT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic signed [OUT_W-1:0] OUT1,
  output logic signed [OUT_W-1:0] OUT2,
  output logic [1:0]              SAT_FLAG,
  output logic [CNT_W-1:0]        SAT_COUNT
);

  logic                    vld_p1, vld_p2;
  logic                    adv1, adv2;
  logic signed [IN_W-1:0]  lane_in    [2];
  logic signed [IN_W:0]    shifted    [2];
  logic signed [IN_W:0]    s1_p1      [2];
  logic signed [OUT_W-1:0] clamped    [2];
  logic [1:0]              sat_nxt;
  logic signed [OUT_W-1:0] out1_p2, out2_p2;
  logic [1:0]              flag_p2;
  logic [CNT_W-1:0]        cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] f);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(f[0]) + (CNT_W+1)'(f[1]);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign lane_in[0] = IN1;
  assign lane_in[1] = IN2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    dsp_norm_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .sum    (lane_in[g]),
      .shift  (SHIFT),
      .shifted(shifted[g]),
      .held   (s1_p1[g]),
      .clamped(clamped[g]),
      .sat    (sat_nxt[g])
    );
  end

  assign adv2     = !vld_p2 || OUT_READY;
  assign adv1     = !vld_p1 || adv2;
  assign IN_READY = adv1;

  // Stage 1: rounded, shifted lane sums
  always_ff @(posedge CLK) begin
    if (adv1) begin
      s1_p1[0] <= shifted[0];
      s1_p1[1] <= shifted[1];
    end
  end

  // Stage 2: clamped outputs, flags and event counter; frozen while the consumer stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      out1_p2 <= '0;
      out2_p2 <= '0;
      flag_p2 <= '0;
      cnt     <= '0;
    end else begin
      if (adv1) begin
        vld_p1 <= IN_VALID;
      end
      if (adv2) begin
        vld_p2  <= vld_p1;
        out1_p2 <= clamped[0];
        out2_p2 <= clamped[1];
        flag_p2 <= vld_p1 ? sat_nxt : 2'b00;
        if (vld_p1) begin
          cnt <= sat_add(cnt, sat_nxt);
        end
      end
    end
  end

  assign OUT_VALID = vld_p2;
  assign OUT1      = out1_p2;
  assign OUT2      = out2_p2;
  assign SAT_FLAG  = flag_p2;
  assign SAT_COUNT = cnt;

endmodule

// File: tb/tb_dsp_sum_normalizer.sv
// Self-checking bench for dsp_sum_normalizer; expectations follow DSP_NORM_ROUND_EN when defined.
// The DUT runs with a 4-bit saturation counter so counter saturation is reachable quickly.
module tb_dsp_sum_normalizer;

  localparam int CW = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               IN_VALID;
  logic               IN_READY;
  logic signed [24:0] IN1, IN2;
  logic [2:0]         SHIFT;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic signed [23:0] OUT1, OUT2;
  logic [1:0]         SAT_FLAG;
  logic [CW-1:0]      SAT_COUNT;

  typedef struct {
    logic signed [23:0] o1;
    logic signed [23:0] o2;
    logic [1:0]         flag;
  } beat_t;

  beat_t exp_q[$];
  int    exp_cnt;
  int    tests, fails;

  logic               cap_ov, cap_ordy, cap_ir, cap_in_fire;
  logic signed [23:0] cap_o1, cap_o2;
  logic [1:0]         cap_flag;
  int                 cap_occ;

  dsp_sum_normalizer #(
    .IN_W(25), .OUT_W(24), .SHIFT_W(3), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN1(IN1), .IN2(IN2), .SHIFT(SHIFT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT1(OUT1), .OUT2(OUT2), .SAT_FLAG(SAT_FLAG), .SAT_COUNT(SAT_COUNT)
  );

  always #5 CLK = ~CLK;

  // Reference: floor((x + rnd) / 2^sh) then clamp to the signed 24-bit range.
  function automatic logic signed [23:0] lane_model(input longint x, input int sh, output logic sat);
    longint t, d, q;
    t = x;
`ifdef DSP_NORM_ROUND_EN
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
`endif
    d = longint'(1) << sh;
    q = t / d;
    if ((t % d != 0) && (t < 0)) q = q - 1;
    sat = 1'b0;
    if (q > 8388607) begin
      q = 8388607; sat = 1'b1;
    end else if (q < -8388608) begin
      q = -8388608; sat = 1'b1;
    end
    return 24'(q);
  endfunction

  function automatic beat_t model(input longint a, input longint b, input int sh);
    beat_t r;
    logic s0, s1;
    r.o1 = lane_model(a, sh, s0);
    r.o2 = lane_model(b, sh, s1);
    r.flag = {s1, s0};
    return r;
  endfunction

  task automatic rand_beat();
    IN1   = 25'($urandom);
    IN2   = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'($signed($urandom_range(0, 2000)) - 1000);
    SHIFT = 3'($urandom_range(0, 7));
  endtask

  // One clock: sample handshake and outputs just before the edge, record accepted beats.
  task automatic step();
    beat_t b;
    int    n;
    #1;
    cap_ov = OUT_VALID; cap_ordy = OUT_READY; cap_ir = IN_READY;
    cap_o1 = OUT1; cap_o2 = OUT2; cap_flag = SAT_FLAG;
    cap_occ = exp_q.size();
    cap_in_fire = IN_VALID && IN_READY;
    if (cap_in_fire) begin
      b = model(IN1, IN2, int'(SHIFT));
      exp_q.push_back(b);
      n = exp_cnt + int'(b.flag[0]) + int'(b.flag[1]);
      exp_cnt = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b want=0", OUT_VALID); end
    tests++; if (OUT1 !== 24'sd0 || OUT2 !== 24'sd0) begin fails++; $display("FAIL reset_outs got=%0d,%0d want=0,0", OUT1, OUT2); end
    tests++; if (SAT_FLAG !== 2'b00) begin fails++; $display("FAIL reset_sat_flag got=%b want=00", SAT_FLAG); end
    tests++; if (SAT_COUNT !== '0) begin fails++; $display("FAIL reset_sat_count got=%0d want=0", SAT_COUNT); end
    RST = 1'b0;
    #1;
    tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b want=1", IN_READY); end
    exp_q.delete(); exp_cnt = 0;
  endtask

  task automatic test_directed();
    int    va[5] = '{9310009, 9310009, -5, -16777216, 16777215};
    int    vb[5] = '{8289400, -16777216, 5, 0, -16777216};
    int    vs[5] = '{1, 0, 1, 3, 7};
`ifdef DSP_NORM_ROUND_EN
    int    c1[5] = '{4655005, 8388607, -2, -2097152, 131072};
`else
    int    c1[5] = '{4655004, 8388607, -3, -2097152, 131071};
`endif
    beat_t e;
    int    n;
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      IN1 = 25'(va[i]); IN2 = 25'(vb[i]); SHIFT = 3'(vs[i]); IN_VALID = 1'b1;
      step();
      tests++; if (cap_ir !== 1'b1) begin fails++; $display("FAIL dir_in_ready[%0d] got=%0b want=1", i, cap_ir); end
      IN_VALID = 1'b0;
      n = 1;
      while (!OUT_VALID && n < 8) begin @(posedge CLK); #1; n++; end
      tests++; if (n != 2) begin fails++; $display("FAIL dir_latency[%0d] got=%0d want=2", i, n); end
      if (exp_q.size() == 0) begin
        tests++; fails++; $display("FAIL dir_queue[%0d] got=empty want=beat", i);
      end else begin
        e = exp_q.pop_front();
        tests++; if (OUT1 !== e.o1 || OUT2 !== e.o2 || SAT_FLAG !== e.flag) begin
          fails++; $display("FAIL dir_data[%0d] got=%0d,%0d,%b want=%0d,%0d,%b", i, OUT1, OUT2, SAT_FLAG, e.o1, e.o2, e.flag);
        end
        tests++; if (OUT1 !== 24'(c1[i])) begin fails++; $display("FAIL dir_const[%0d] got=%0d want=%0d", i, OUT1, c1[i]); end
      end
    end
    step();
    tests++; if (SAT_COUNT !== CW'(exp_cnt) || exp_cnt != 2) begin
      fails++; $display("FAIL dir_sat_count got=%0d want=%0d (model %0d)", SAT_COUNT, 2, exp_cnt);
    end
  endtask

  task automatic test_stream_stall();
    int    sent = 0, got = 0, stall = 0, cyc = 0, lows = 0;
    logic  prev_hold = 1'b0;
    logic signed [23:0] p1, p2;
    logic [1:0] pf;
    beat_t e;
    rand_beat();
    while (got < 8 && cyc < 200) begin
      IN_VALID  = (sent < 8);
      OUT_READY = (stall == 0);
      if (stall > 0) stall--;
      step();
      if (cap_in_fire) begin sent++; rand_beat(); end
      tests++; if (cap_ir !== !(cap_occ == 2 && !cap_ordy)) begin
        fails++; $display("FAIL stall_in_ready cyc=%0d got=%0b want=%0b", cyc, cap_ir, !(cap_occ == 2 && !cap_ordy));
      end
      if (!cap_ir) lows++;
      if (prev_hold) begin
        tests++; if (cap_o1 !== p1 || cap_o2 !== p2 || cap_flag !== pf) begin
          fails++; $display("FAIL stall_stable cyc=%0d got=%0d,%0d want=%0d,%0d", cyc, cap_o1, cap_o2, p1, p2);
        end
      end
      prev_hold = cap_ov && !cap_ordy; p1 = cap_o1; p2 = cap_o2; pf = cap_flag;
      if (cap_ov && cap_ordy) begin
        if (exp_q.size() == 0) begin
          tests++; fails++; $display("FAIL stall_extra_beat got=%0d want=none", cap_o1);
        end else begin
          e = exp_q.pop_front();
          tests++; if (cap_o1 !== e.o1 || cap_o2 !== e.o2 || cap_flag !== e.flag) begin
            fails++; $display("FAIL stall_data[%0d] got=%0d,%0d,%b want=%0d,%0d,%b", got, cap_o1, cap_o2, cap_flag, e.o1, e.o2, e.flag);
          end
        end
        got++;
        if (got == 2) stall = 4;
      end
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tests++; if (got != 8 || exp_q.size() != 0) begin fails++; $display("FAIL stall_delivered got=%0d want=8", got); end
    tests++; if (lows == 0) begin fails++; $display("FAIL stall_backpressure got=%0d want=>0", lows); end
    tests++; if (SAT_COUNT !== CW'(exp_cnt)) begin fails++; $display("FAIL stall_sat_count got=%0d want=%0d", SAT_COUNT, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int    cyc = 0;
    beat_t e;
    rand_beat();
    while (cyc < 300 && (cyc < 80 || exp_q.size() != 0)) begin
      IN_VALID  = (cyc < 80) && (cyc < 20 || $urandom_range(0, 3) != 0);
      OUT_READY = (cyc < 20 || cyc >= 80) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      step();
      if (cap_in_fire) rand_beat();
      tests++; if (cap_ir !== !(cap_occ == 2 && !cap_ordy)) begin
        fails++; $display("FAIL b2b_in_ready cyc=%0d got=%0b want=%0b", cyc, cap_ir, !(cap_occ == 2 && !cap_ordy));
      end
      if (cap_ov && cap_ordy) begin
        if (exp_q.size() == 0) begin
          tests++; fails++; $display("FAIL b2b_extra_beat got=%0d want=none", cap_o1);
        end else begin
          e = exp_q.pop_front();
          tests++; if (cap_o1 !== e.o1 || cap_o2 !== e.o2 || cap_flag !== e.flag) begin
            fails++; $display("FAIL b2b_data cyc=%0d got=%0d,%0d,%b want=%0d,%0d,%b", cyc, cap_o1, cap_o2, cap_flag, e.o1, e.o2, e.flag);
          end
        end
      end
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain got=%0d pending want=0", exp_q.size()); end
    tests++; if (SAT_COUNT !== CW'(exp_cnt)) begin fails++; $display("FAIL b2b_sat_count got=%0d want=%0d", SAT_COUNT, exp_cnt); end
  endtask

  task automatic test_reset_flush();
    beat_t e;
    int    n;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; exp_q.delete(); exp_cnt = 0;
    OUT_READY = 1'b0;
    IN1 = 25'sh0FFFFFF; IN2 = -25'sd16777216; SHIFT = 3'd0; IN_VALID = 1'b1;
    step();
    IN1 = 25'sd1234; IN2 = -25'sd4321; SHIFT = 3'd2;
    step();
    IN_VALID = 1'b0;
    tests++; if (OUT_VALID !== 1'b1 || SAT_COUNT !== CW'(2)) begin
      fails++; $display("FAIL flush_pre got=%0b,%0d want=1,2", OUT_VALID, SAT_COUNT);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; exp_q.delete(); exp_cnt = 0;
    tests++; if (OUT_VALID !== 1'b0 || SAT_COUNT !== '0 || SAT_FLAG !== 2'b00) begin
      fails++; $display("FAIL flush_post got=%0b,%0d,%b want=0,0,00", OUT_VALID, SAT_COUNT, SAT_FLAG);
    end
    OUT_READY = 1'b1; rand_beat(); IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 8) begin @(posedge CLK); #1; n++; end
    tests++; if (n != 2) begin fails++; $display("FAIL flush_latency got=%0d want=2", n); end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++; if (OUT1 !== e.o1 || OUT2 !== e.o2 || SAT_FLAG !== e.flag) begin
        fails++; $display("FAIL flush_data got=%0d,%0d,%b want=%0d,%0d,%b", OUT1, OUT2, SAT_FLAG, e.o1, e.o2, e.flag);
      end
    end
    @(posedge CLK); #1;
    tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL flush_no_stale got=%0b want=0", OUT_VALID); end
  endtask

  task automatic test_sat_count();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; exp_q.delete(); exp_cnt = 0;
    IN1 = 25'sh0FFFFFF; IN2 = -25'sd16777216; SHIFT = 3'd0;
    for (int k = 0; k < 10; k++) begin
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      repeat (3) step();
      tests++; if (SAT_COUNT !== CW'(exp_cnt)) begin fails++; $display("FAIL satcnt[%0d] got=%0d want=%0d", k, SAT_COUNT, exp_cnt); end
      if (k == 6) begin
        tests++; if (SAT_COUNT !== 4'hE) begin fails++; $display("FAIL satcnt_e got=%0h want=e", SAT_COUNT); end
      end
      if (k >= 7) begin
        tests++; if (SAT_COUNT !== 4'hF) begin fails++; $display("FAIL satcnt_hold[%0d] got=%0h want=f", k, SAT_COUNT); end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    tests = 0; fails = 0; exp_cnt = 0;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN1 = '0; IN2 = '0; SHIFT = '0;
    test_reset();
    test_directed();
    test_stream_stall();
    test_back_to_back();
    test_reset_flush();
    test_sat_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
